vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Responder for the screen controller's video fetch interface; owns the external 512K SRAM bus.
- Serves screen bitmap/attribute/ULAplus fetches and CPU reads/writes, one 14 MHz slot per access.
- Issues fetch_allow to the screen and throttles it so a waiting CPU access is never starved.
- Sits between the screen controller, the CPU bus glue and the SRAM pins.

Parameters:
- UP_BASE, 19'h7FFC0, SRAM base of the 64-byte ULAplus palette.
- CPU_MAX_WAIT, 2, slots a CPU request may wait before fetch_allow is dropped.

Ports:
- clk28  input  1  28 MHz clock
- rst_n  input  1  reset, asynchronous, active-low
- ck14  input  1  one-cycle strobe every 2 clk28 cycles; marks slot end (phase B)
- screen_fetch  input  1  screen access requested for the current slot
- screen_fetch_up  input  1  current fetch targets the ULAplus palette
- screen_addr  input  15  screen offset; bits [13:0] used
- screen_up_addr  input  6  palette index
- screen_page  input  1  0 = RAM page 5, 1 = RAM page 7
- fetch_allow  output  1  screen may fetch next slot
- fetch_data  output  8  fetched byte, valid in phase B
- cpu_req  input  1  level; held until cpu_ack
- cpu_we  input  1  1 = write
- cpu_addr  input  19  physical SRAM address
- cpu_wdata  input  8  write data
- cpu_rdata  output  8  read data, valid with cpu_ack
- cpu_ack  output  1  one-cycle completion pulse
- ra  output  19  SRAM address
- rd_out  output  8  SRAM write data
- rd_in  input  8  SRAM read data
- rd_oe  output  1  drive rd_out onto SRAM bus
- n_roe  output  1  SRAM output enable, active-low
- n_rwe  output  1  SRAM write enable, active-low

Behaviour:
- Slot: phase A = clk28 cycle after ck14; phase B = cycle with ck14=1. Owner is decided at the ck14 edge that starts the slot, held for the whole slot.
- States: IDLE, SCR, CPU_RD, CPU_WR.
- Selection at slot start:
  - SCR if screen_fetch=1.
  - else CPU_RD or CPU_WR if cpu_req=1.
  - else IDLE.
  - Screen always wins a tie.
- SCR:
  - ra = {2'b00, screen_page ? 3'd7 : 3'd5, screen_addr[13:0]}.
  - If screen_fetch_up, ra = UP_BASE | screen_up_addr instead.
  - n_roe=0 for both phases.
  - fetch_data <= rd_in at the end of phase A; the screen samples it at the phase-B ck14.
- CPU_RD:
  - ra = cpu_addr, n_roe=0.
  - cpu_rdata <= rd_in at the end of phase A.
  - cpu_ack=1 in phase B.
- CPU_WR:
  - ra = cpu_addr, rd_oe=1, rd_out=cpu_wdata both phases.
  - n_rwe=0 in phase B only (address setup in A).
  - cpu_ack=1 in phase B.
- IDLE: n_roe=n_rwe=1, rd_oe=0; ra holds its last value.
- Starvation counter, 2 bits, saturating:
  - Increments at each slot start with cpu_req=1 and owner != CPU.
  - Clears on cpu_ack or when cpu_req=0.
  - fetch_allow = (count < CPU_MAX_WAIT), registered, updated at ck14.
  - If the screen fetches while fetch_allow=0, the screen still wins; the counter holds at saturation.
- Latencies:
  - CPU access completes in 1 slot when the bus is free.
  - Worst case is CPU_MAX_WAIT+2 slots.
- cpu_req dropped before ack: the request is abandoned at the next slot start. A slot already started completes without ack side-effects, except the write is still performed.
- cpu_req must stay high one cycle past cpu_ack before a new request is sampled. The arbiter ignores cpu_req in the slot immediately following an ack.
- Reset values (asynchronous, immediate mid-slot):
  - State IDLE.
  - n_roe=1, n_rwe=1, rd_oe=0.
  - ra=0, rd_out=0.
  - fetch_allow=1.
  - fetch_data=8'hFF, cpu_rdata=8'hFF, cpu_ack=0.
  - Counter 0.

Decomposition:
- Add a slot-owner enum (OWN_IDLE, OWN_SCR, OWN_CPU_RD, OWN_CPU_WR) and page constants (PAGE_SCR0=5, PAGE_SCR1=7) to the common package.
- Single module; no sub-module needed.

Test Plan:
- Screen only: screen_fetch=1, screen_addr=15'h1800, page=0, SRAM model returns 8'hA5 -> ra=19'h15800, n_roe=0 for 2 cycles, fetch_data=8'hA5 at phase B.
- ULAplus fetch: screen_fetch_up=1, screen_up_addr=6'h3F -> ra=19'h7FFFF.
- CPU write on idle bus: cpu_req=1, cpu_we=1, addr=19'h12345, wdata=8'h5A -> n_rwe low exactly in phase B of the next slot, cpu_ack pulse, model holds 8'h5A.
- Contention: screen_fetch held high continuously with cpu_req=1 -> fetch_allow drops after 2 slots; the CPU gets the first slot where screen_fetch=0; fetch_allow returns to 1 after the ack.
- Simultaneous: screen_fetch and cpu_req assert together -> screen slot first, CPU slot next, cpu_rdata matches the model.
- Reset mid CPU_WR phase A -> n_rwe stays 1, rd_oe=0, no ack, fetch_allow=1 immediately.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared types and constants for the video RAM arbiter.
// Slot owner encoding and the SRAM page numbers holding the two screens.
package vram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_SCR,
    OWN_CPU_RD,
    OWN_CPU_WR
  } slot_owner_e;

  localparam logic [2:0] PAGE_SCR0 = 3'd5;
  localparam logic [2:0] PAGE_SCR1 = 3'd7;

  function automatic logic [18:0] screen_ra(input logic page, input logic [13:0] offset);
    return {2'b00, (page ? PAGE_SCR1 : PAGE_SCR0), offset};
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Owns the 512K SRAM bus: one 14 MHz slot per access, screen first, with a
// starvation counter that withdraws fetch_allow so a waiting CPU access gets through.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter logic [18:0] UP_BASE      = 19'h7FFC0,
  parameter int unsigned CPU_MAX_WAIT = 2
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        ck14,
  input  logic        screen_fetch,
  input  logic        screen_fetch_up,
  input  logic [14:0] screen_addr,
  input  logic [5:0]  screen_up_addr,
  input  logic        screen_page,
  output logic        fetch_allow,
  output logic [7:0]  fetch_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [18:0] ra,
  output logic [7:0]  rd_out,
  input  logic [7:0]  rd_in,
  output logic        rd_oe,
  output logic        n_roe,
  output logic        n_rwe
);

  slot_owner_e owner_q, owner_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [18:0] ra_d;
  logic        cpu_pending;
  logic        unused_screen_addr;

  assign unused_screen_addr = screen_addr[14];

  // A just-acked request is still high for one slot; it must not be served twice.
  assign cpu_pending = cpu_req & ~cpu_ack;

  always_comb begin
    owner_d = OWN_IDLE;
    if (screen_fetch) begin
      owner_d = OWN_SCR;
    end else if (cpu_pending) begin
      owner_d = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!cpu_pending) begin
      wait_cnt_d = 2'd0;
    end else if (owner_d == OWN_SCR && wait_cnt_q != 2'd3) begin
      wait_cnt_d = wait_cnt_q + 2'd1;
    end
  end

  always_comb begin
    ra_d = ra;
    case (owner_d)
      OWN_SCR: begin
        ra_d = screen_fetch_up ? (UP_BASE | {13'd0, screen_up_addr})
                               : screen_ra(screen_page, screen_addr[13:0]);
      end
      OWN_CPU_RD, OWN_CPU_WR: ra_d = cpu_addr;
      default:                ra_d = ra;
    endcase
  end

  // ck14 high: slot boundary (end of phase B). ck14 low: end of phase A.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_IDLE;
      wait_cnt_q  <= 2'd0;
      fetch_allow <= 1'b1;
      ra          <= 19'd0;
      rd_out      <= 8'd0;
      rd_oe       <= 1'b0;
      n_roe       <= 1'b1;
      n_rwe       <= 1'b1;
      fetch_data  <= 8'hFF;
      cpu_rdata   <= 8'hFF;
      cpu_ack     <= 1'b0;
    end else if (ck14) begin
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_allow <= ({30'd0, wait_cnt_d} < CPU_MAX_WAIT);
      ra          <= ra_d;
      if (owner_d == OWN_CPU_WR) begin
        rd_out <= cpu_wdata;
      end
      rd_oe   <= (owner_d == OWN_CPU_WR);
      n_roe   <= ~((owner_d == OWN_SCR) || (owner_d == OWN_CPU_RD));
      n_rwe   <= 1'b1;
      cpu_ack <= 1'b0;
    end else begin
      case (owner_q)
        OWN_SCR: fetch_data <= rd_in;
        OWN_CPU_RD: begin
          if (cpu_req) begin
            cpu_rdata <= rd_in;
            cpu_ack   <= 1'b1;
          end
        end
        // An abandoned write still strobes the SRAM, just without an ack.
        OWN_CPU_WR: begin
          n_rwe   <= 1'b0;
          cpu_ack <= cpu_req;
        end
        default: ;
      endcase
    end
  end

endmodule
